// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the RV32IM instruction encoder:
// op selector, opcode/funct constants, immediate ranges and per-op control info.
package instr_encoder_pkg;

    typedef enum logic [5:0] {
        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
        OP_SB, OP_SH, OP_SW,
        OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
        OP_SLLI, OP_SRLI, OP_SRAI,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU,
        OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU
    } op_t;

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    localparam logic signed [31:0] IMM_I_MIN = -32'sd2048;
    localparam logic signed [31:0] IMM_I_MAX = 32'sd2047;
    localparam logic signed [31:0] IMM_B_MIN = -32'sd4096;
    localparam logic signed [31:0] IMM_B_MAX = 32'sd4094;
    localparam logic signed [31:0] IMM_J_MIN = -32'sd1048576;
    localparam logic signed [31:0] IMM_J_MAX = 32'sd1048574;

    typedef struct packed {
        fmt_t       fmt;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } control_info_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic        err;
    } out_word_t;

    function automatic control_info_t mk(fmt_t f, logic [6:0] o,
                                         logic [2:0] f3, logic [6:0] f7);
        control_info_t c;
        c.fmt    = f;
        c.opcode = o;
        c.funct3 = f3;
        c.funct7 = f7;
        return c;
    endfunction

    function automatic control_info_t control_info(op_t op);
        control_info_t c;
        c = mk(FMT_BAD, 7'd0, 3'd0, F7_BASE);
        case (op)
            OP_LUI:    c = mk(FMT_U, OPC_LUI,    3'd0, F7_BASE);
            OP_AUIPC:  c = mk(FMT_U, OPC_AUIPC,  3'd0, F7_BASE);
            OP_JAL:    c = mk(FMT_J, OPC_JAL,    3'd0, F7_BASE);
            OP_JALR:   c = mk(FMT_I, OPC_JALR,   3'd0, F7_BASE);
            OP_BEQ:    c = mk(FMT_B, OPC_BRANCH, 3'd0, F7_BASE);
            OP_BNE:    c = mk(FMT_B, OPC_BRANCH, 3'd1, F7_BASE);
            OP_BLT:    c = mk(FMT_B, OPC_BRANCH, 3'd4, F7_BASE);
            OP_BGE:    c = mk(FMT_B, OPC_BRANCH, 3'd5, F7_BASE);
            OP_BLTU:   c = mk(FMT_B, OPC_BRANCH, 3'd6, F7_BASE);
            OP_BGEU:   c = mk(FMT_B, OPC_BRANCH, 3'd7, F7_BASE);
            OP_LB:     c = mk(FMT_I, OPC_LOAD,   3'd0, F7_BASE);
            OP_LH:     c = mk(FMT_I, OPC_LOAD,   3'd1, F7_BASE);
            OP_LW:     c = mk(FMT_I, OPC_LOAD,   3'd2, F7_BASE);
            OP_LBU:    c = mk(FMT_I, OPC_LOAD,   3'd4, F7_BASE);
            OP_LHU:    c = mk(FMT_I, OPC_LOAD,   3'd5, F7_BASE);
            OP_SB:     c = mk(FMT_S, OPC_STORE,  3'd0, F7_BASE);
            OP_SH:     c = mk(FMT_S, OPC_STORE,  3'd1, F7_BASE);
            OP_SW:     c = mk(FMT_S, OPC_STORE,  3'd2, F7_BASE);
            OP_ADDI:   c = mk(FMT_I, OPC_OPIMM,  3'd0, F7_BASE);
            OP_SLTI:   c = mk(FMT_I, OPC_OPIMM,  3'd2, F7_BASE);
            OP_SLTIU:  c = mk(FMT_I, OPC_OPIMM,  3'd3, F7_BASE);
            OP_XORI:   c = mk(FMT_I, OPC_OPIMM,  3'd4, F7_BASE);
            OP_ORI:    c = mk(FMT_I, OPC_OPIMM,  3'd6, F7_BASE);
            OP_ANDI:   c = mk(FMT_I, OPC_OPIMM,  3'd7, F7_BASE);
            OP_SLLI:   c = mk(FMT_SH, OPC_OPIMM, 3'd1, F7_BASE);
            OP_SRLI:   c = mk(FMT_SH, OPC_OPIMM, 3'd5, F7_BASE);
            OP_SRAI:   c = mk(FMT_SH, OPC_OPIMM, 3'd5, F7_ALT);
            OP_ADD:    c = mk(FMT_R, OPC_OP,     3'd0, F7_BASE);
            OP_SUB:    c = mk(FMT_R, OPC_OP,     3'd0, F7_ALT);
            OP_SLL:    c = mk(FMT_R, OPC_OP,     3'd1, F7_BASE);
            OP_SLT:    c = mk(FMT_R, OPC_OP,     3'd2, F7_BASE);
            OP_SLTU:   c = mk(FMT_R, OPC_OP,     3'd3, F7_BASE);
            OP_XOR:    c = mk(FMT_R, OPC_OP,     3'd4, F7_BASE);
            OP_SRL:    c = mk(FMT_R, OPC_OP,     3'd5, F7_BASE);
            OP_SRA:    c = mk(FMT_R, OPC_OP,     3'd5, F7_ALT);
            OP_OR:     c = mk(FMT_R, OPC_OP,     3'd6, F7_BASE);
            OP_AND:    c = mk(FMT_R, OPC_OP,     3'd7, F7_BASE);
            OP_MUL:    c = mk(FMT_R, OPC_OP,     3'd0, F7_MUL);
            OP_MULH:   c = mk(FMT_R, OPC_OP,     3'd1, F7_MUL);
            OP_MULHSU: c = mk(FMT_R, OPC_OP,     3'd2, F7_MUL);
            OP_MULHU:  c = mk(FMT_R, OPC_OP,     3'd3, F7_MUL);
            OP_DIV:    c = mk(FMT_R, OPC_OP,     3'd4, F7_MUL);
            OP_DIVU:   c = mk(FMT_R, OPC_OP,     3'd5, F7_MUL);
            OP_REM:    c = mk(FMT_R, OPC_OP,     3'd6, F7_MUL);
            OP_REMU:   c = mk(FMT_R, OPC_OP,     3'd7, F7_MUL);
            default:   c = mk(FMT_BAD, 7'd0, 3'd0, F7_BASE);
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request/response handshake bundle between a requester and the encoder.
interface instr_encoder_if;
    import instr_encoder_pkg::*;

    logic        in_valid;
    logic        in_ready;
    op_t         in_op;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err
    );

endinterface

// File: rtl/instr_encoder_format.sv
// Combinational field packer and immediate range checker.
module instr_format
    import instr_encoder_pkg::*;
(
    input  op_t         op_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    input  logic [31:0] imm_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    control_info_t     ci;
    logic signed [31:0] simm;
    logic [31:0]       word;
    logic              bad;

    assign simm = imm_i;

    always_comb begin
        ci   = control_info(op_i);
        word = '0;
        bad  = 1'b0;
        case (ci.fmt)
            FMT_R: word = {ci.funct7, rs2_i, rs1_i, ci.funct3, rd_i, ci.opcode};
            FMT_I: begin
                word = {imm_i[11:0], rs1_i, ci.funct3, rd_i, ci.opcode};
                bad  = (simm < IMM_I_MIN) || (simm > IMM_I_MAX);
            end
            FMT_SH: begin
                word = {ci.funct7, imm_i[4:0], rs1_i, ci.funct3, rd_i, ci.opcode};
                bad  = |imm_i[31:5];
            end
            FMT_S: begin
                word = {imm_i[11:5], rs2_i, rs1_i, ci.funct3,
                        imm_i[4:0], ci.opcode};
                bad  = (simm < IMM_I_MIN) || (simm > IMM_I_MAX);
            end
            FMT_B: begin
                word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, ci.funct3,
                        imm_i[4:1], imm_i[11], ci.opcode};
                bad  = imm_i[0] || (simm < IMM_B_MIN) || (simm > IMM_B_MAX);
            end
            FMT_U: begin
                word = {imm_i[31:12], rd_i, ci.opcode};
                bad  = |imm_i[11:0];
            end
            FMT_J: begin
                word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                        rd_i, ci.opcode};
                bad  = imm_i[0] || (simm < IMM_J_MIN) || (simm > IMM_J_MAX);
            end
            default: bad = 1'b1;
        endcase
        instr_o = bad ? 32'h0 : word;
        err_o   = bad;
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32IM encoder: one-cycle latency with an output register plus skid slot,
// sequential address assignment and a saturating error counter.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    instr_encoder_if.slave        bus,
    output logic [15:0]           err_count_o
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t      state_q, state_d;
    out_word_t   out_q, skid_q, enc_w;
    logic [31:0] addr_q;
    logic [15:0] err_cnt_q;
    logic        in_ready_q, out_valid_q;
    logic        accept, drain;
    logic [31:0] f_instr;
    logic        f_err;

    instr_format u_fmt (
        .op_i    (bus.in_op),
        .rd_i    (bus.in_rd),
        .rs1_i   (bus.in_rs1),
        .rs2_i   (bus.in_rs2),
        .imm_i   (bus.in_imm),
        .instr_o (f_instr),
        .err_o   (f_err)
    );

    assign accept = bus.in_valid & in_ready_q;
    assign drain  = out_valid_q & bus.out_ready;
    assign enc_w  = '{instr: f_instr, addr: addr_q, err: f_err};

    always_comb begin
        state_d = state_q;
        unique case (1'b1)
            state_q == EMPTY: if (accept) state_d = ONE;
            state_q == ONE: begin
                if (accept && !drain) state_d = TWO;
                else if (drain && !accept) state_d = EMPTY;
            end
            state_q == TWO: if (drain) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '{instr: 32'h0, addr: BASE_ADDR, err: 1'b0};
            skid_q      <= '0;
            addr_q      <= BASE_ADDR;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != TWO);
            out_valid_q <= (state_d != EMPTY);
            if (accept) addr_q <= addr_q + 32'd4;
            // Skid only fills when the output is occupied and not draining
            if (state_q == TWO) begin
                if (drain) out_q <= skid_q;
            end else if (accept) begin
                if (state_q == EMPTY || drain) out_q <= enc_w;
                else skid_q <= enc_w;
            end
            if (drain && out_q.err && err_cnt_q != 16'hFFFF)
                err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_instr = out_q.instr;
    assign bus.out_addr  = out_q.addr;
    assign bus.out_err   = out_q.err;
    assign err_count_o   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        clk;
    logic        rstn;
    logic [15:0] err_count;
    int          vec;
    int          bad;

    instr_encoder_if bus ();

    instr_encoder #(.BASE_ADDR(32'h0)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .bus         (bus),
        .err_count_o (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_req(op_t op, logic [4:0] rd, logic [4:0] rs1,
                           logic [4:0] rs2, logic [31:0] imm);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.in_imm   = imm;
    endtask

    // One request accepted from EMPTY; returns when its word is on OUT.
    task automatic drive(op_t op, logic [4:0] rd, logic [4:0] rs1,
                         logic [4:0] rs2, logic [31:0] imm);
        @(negedge clk);
        set_req(op, rd, rs1, rs2, imm);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
            bus.out_instr !== 32'h0 || bus.out_err !== 1'b0 ||
            bus.out_addr !== 32'h0 || err_count !== 16'h0) begin
            bad++;
            $display("FAIL reset: rdy=%b vld=%b instr=%h err=%b addr=%h cnt=%0d, need 1 0 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.out_instr,
                     bus.out_err, bus.out_addr, err_count);
        end
        rstn = 1'b1;
    endtask

    task automatic test_encode();
        logic [31:0] exp_i [8];
        op_t         ops   [8];
        logic [4:0]  rds   [8];
        logic [4:0]  r1s   [8];
        logic [4:0]  r2s   [8];
        logic [31:0] imms  [8];
        ops = '{OP_ADDI, OP_ADD, OP_SUB, OP_BEQ, OP_LUI, OP_MUL, OP_SRAI, OP_SW};
        rds = '{5'd1, 5'd3, 5'd3, 5'd0, 5'd5, 5'd3, 5'd3, 5'd0};
        r1s = '{5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 5'd1, 5'd1, 5'd1};
        r2s = '{5'd9, 5'd2, 5'd2, 5'd2, 5'd0, 5'd2, 5'd7, 5'd2};
        imms = '{32'd5, 32'd0, 32'd0, 32'd8, 32'h1234_5000, 32'd0,
                 32'd5, 32'hFFFF_FFFC};
        exp_i = '{32'h0050_0093, 32'h0020_81B3, 32'h4020_81B3, 32'h0020_8463,
                  32'h1234_52B7, 32'h0220_81B3, 32'h4050_D193, 32'hFE20_AE23};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(ops[i], rds[i], r1s[i], r2s[i], imms[i]);
            vec++;
            if (bus.out_valid !== 1'b1 || bus.out_instr !== exp_i[i] ||
                bus.out_addr !== 32'(i * 4) || bus.out_err !== 1'b0) begin
                bad++;
                $display("FAIL encode[%0d]: vld=%b instr=%h addr=%h err=%b, need 1 %h %h 0",
                         i, bus.out_valid, bus.out_instr, bus.out_addr,
                         bus.out_err, exp_i[i], 32'(i * 4));
            end
        end
    endtask

    task automatic test_errors();
        op_t         ops  [7];
        logic [31:0] imms [7];
        logic [31:0] exp_i[7];
        logic        exp_e[7];
        ops   = '{OP_JAL, OP_ADDI, OP_ADDI, OP_ADDI, OP_SLLI, OP_LUI,
                  op_t'(6'd63)};
        imms  = '{32'd3, 32'd4096, 32'd2047, 32'hFFFF_F800, 32'd32,
                  32'h1234_5001, 32'd0};
        exp_i = '{32'h0, 32'h0, 32'h7FF0_0093, 32'h8000_0093, 32'h0, 32'h0, 32'h0};
        exp_e = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(ops[i], 5'd1, 5'd0, 5'd0, imms[i]);
            vec++;
            if (bus.out_valid !== 1'b1 || bus.out_instr !== exp_i[i] ||
                bus.out_addr !== 32'(i * 4) || bus.out_err !== exp_e[i]) begin
                bad++;
                $display("FAIL error[%0d]: vld=%b instr=%h addr=%h err=%b, need 1 %h %h %b",
                         i, bus.out_valid, bus.out_instr, bus.out_addr,
                         bus.out_err, exp_i[i], 32'(i * 4), exp_e[i]);
            end
            if (i == 1) begin
                @(negedge clk);
                vec++;
                if (err_count !== 16'd2) begin
                    bad++;
                    $display("FAIL err_count_two: got %0d need 2", err_count);
                end
            end
        end
        @(negedge clk);
        vec++;
        if (err_count !== 16'd5) begin
            bad++;
            $display("FAIL err_count_five: got %0d need 5", err_count);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.out_ready = 1'b0;
        @(negedge clk);
        set_req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
        @(negedge clk);
        set_req(OP_ADDI, 5'd2, 5'd0, 5'd0, 32'd2);
        @(negedge clk);
        set_req(OP_ADDI, 5'd3, 5'd0, 5'd0, 32'd3);
        for (int k = 0; k < 4; k++) begin
            vec++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                bus.out_instr !== 32'h0010_0093 || bus.out_addr !== 32'h0 ||
                bus.out_err !== 1'b0) begin
                bad++;
                $display("FAIL stall[%0d]: rdy=%b vld=%b instr=%h addr=%h, need 0 1 00100093 0",
                         k, bus.in_ready, bus.out_valid, bus.out_instr,
                         bus.out_addr);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        vec++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h0020_0113 ||
            bus.out_addr !== 32'h4) begin
            bad++;
            $display("FAIL release_b: vld=%b instr=%h addr=%h, need 1 00200113 4",
                     bus.out_valid, bus.out_instr, bus.out_addr);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        vec++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h0030_0193 ||
            bus.out_addr !== 32'h8) begin
            bad++;
            $display("FAIL release_c: vld=%b instr=%h addr=%h, need 1 00300193 8",
                     bus.out_valid, bus.out_instr, bus.out_addr);
        end
        @(negedge clk);
        vec++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL drained: vld=%b need 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        // Build up an error count first so the reset is seen to clear it
        bus.out_ready = 1'b1;
        drive(OP_JAL, 5'd1, 5'd0, 5'd0, 32'd3);
        @(negedge clk);
        bus.out_ready = 1'b0;
        set_req(OP_ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
        @(negedge clk);
        set_req(OP_ADDI, 5'd2, 5'd0, 5'd0, 32'd2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        vec++;
        if (bus.in_ready !== 1'b0 || err_count !== 16'd1) begin
            bad++;
            $display("FAIL pre_reset: rdy=%b cnt=%0d, need 0 1",
                     bus.in_ready, err_count);
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        vec++;
        if (bus.out_valid !== 1'b0 || err_count !== 16'd0 ||
            bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset: vld=%b cnt=%0d rdy=%b, need 0 0 1",
                     bus.out_valid, err_count, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        drive(OP_ADDI, 5'd5, 5'd0, 5'd0, 32'd7);
        vec++;
        if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h0070_0293 ||
            bus.out_addr !== 32'h0) begin
            bad++;
            $display("FAIL post_reset: vld=%b instr=%h addr=%h, need 1 00700293 0",
                     bus.out_valid, bus.out_instr, bus.out_addr);
        end
        @(negedge clk);
        vec++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_drain: vld=%b need 0", bus.out_valid);
        end
    endtask

    initial begin
        vec = 0;
        bad = 0;
        rstn = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_op     = OP_ADDI;
        bus.in_rd     = '0;
        bus.in_rs1    = '0;
        bus.in_rs2    = '0;
        bus.in_imm    = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_encode();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: BASE_ADDR, 32'h0000_0000, address assigned to the first encoded word after reset.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RSTN  in  1  reset; synchronous and active-low.
REQ-004 IN_VALID  in  1  request carries a valid instruction description.
REQ-005 IN_READY  out  1  encoder accepts the request this cycle.
REQ-006 IN_OP  in  op_t  instruction selector: RV32I base plus RV32M.
REQ-007 IN_RD / IN_RS1 / IN_RS2  in  5 each  register indices.
REQ-008 IN_IMM  in  32  immediate as a full signed byte value; U-type carries the upper-20 value pre-shifted.
REQ-009 OUT_VALID  out  1  OUT_INSTR/OUT_ADDR/OUT_ERR valid.
REQ-010 OUT_READY  in  1  downstream consumes the output this cycle.
REQ-011 OUT_INSTR  out  32  encoded instruction word.
REQ-012 OUT_ADDR  out  32  byte address of OUT_INSTR.
REQ-013 OUT_ERR  out  1  request was unencodable; OUT_INSTR is 32'h0000_0000.
REQ-014 ERR_COUNT  out  16  saturating count of erroneous words emitted.

Function
REQ-015 A transfer on either side SHALL occur only when VALID and READY are both 1 in the same cycle.
REQ-016 Latency SHALL be 1 cycle: a request accepted in cycle N is presented on OUT in cycle N+1 if the output register is free.
REQ-017 Buffering: output register plus one skid register; states EMPTY, ONE, TWO.
REQ-018 EMPTY: accept -> ONE. ONE: accept without drain -> TWO; drain without accept -> EMPTY; both -> ONE.
REQ-019 TWO: drain moves skid to output -> ONE; no accept is possible in TWO.
REQ-020 IN_READY SHALL be a register output equal to (state != TWO); no combinational path from OUT_READY.
REQ-021 Output order SHALL equal acceptance order; no request is dropped or duplicated.
REQ-022 OUT_INSTR/ADDR/ERR SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-023 The address counter SHALL start at BASE_ADDR, advance by 4 per accepted request, and wrap modulo 2^32.
REQ-024 Formats: R, I, S, B, U and J fields are packed per the RISC-V spec; RV32M uses funct7=0000001.
REQ-025 slli/srli/srai: shamt=IN_IMM[4:0]; funct7 is 0000000, or 0100000 for srai.
REQ-026 Fields a format does not use (e.g. rs2 in I-type) SHALL be ignored.
REQ-027 Errors: OUT_ERR=1 on any of the following; OUT_INSTR=0 and the address is still consumed:
- I/S imm outside [-2048, 2047];
- B imm odd or outside [-4096, 4094];
- J imm odd or outside [-2^20, 2^20-2];
- U IN_IMM[11:0] != 0;
- shift imm outside [0, 31];
- undefined IN_OP.
REQ-028 ERR_COUNT SHALL increment on an output transfer with OUT_ERR=1 and saturate at 16'hFFFF.

Reset
REQ-029 While RSTN=0 at a clock edge, the block SHALL reset as follows:
- state=EMPTY; OUT_VALID=0; IN_READY=1;
- OUT_INSTR=0; OUT_ERR=0; OUT_ADDR=BASE_ADDR;
- address counter=BASE_ADDR; ERR_COUNT=0.
REQ-030 Reset mid-operation SHALL discard buffered words without emitting them; the first request after reset is encoded at BASE_ADDR.

Structure
REQ-031 op_t, opcode/funct3/funct7 constants and immediate-range constants SHALL live in the shared def package, beside control_info.
REQ-032 Packing and range checking SHALL be one combinational sub-module, instr_format (op + fields -> word, err).
REQ-033 instr_encoder SHALL hold the handshake FSM, skid register, address counter and error counter.

Verification
REQ-034 addi rd=1, rs1=0, imm=5 -> OUT_INSTR=0x00500093, OUT_ADDR=0, OUT_ERR=0, one cycle after accept.
REQ-035 add 3,1,2 -> 0x002081B3; sub 3,1,2 -> 0x402081B3; beq 1,2, imm=8 -> 0x00208463; lui 5, 0x12345000 -> 0x123452B7.
REQ-036 jal imm=3, then addi imm=4096 -> two words, OUT_ERR=1, OUT_INSTR=0, ERR_COUNT=2, addresses 0 and 4.
REQ-037 OUT_READY=0 while 3 requests are offered back-to-back:
- exactly 2 are accepted, then IN_READY=0;
- on release, outputs appear in order at addresses 0 and 4, then the third at 8;
- OUT holds stable throughout the stall.
REQ-038 RSTN=0 for one cycle while in TWO:
- OUT_VALID=0 and ERR_COUNT=0 next cycle;
- the next accepted addi is emitted at BASE_ADDR.
